// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester and UART_Tx side signals of the UART TX arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   i_req;
    logic [8*NUM_REQ-1:0] i_reqBytes;
    logic [NUM_REQ-1:0]   o_ack;
    logic                 o_txStart;
    logic [7:0]           o_txByte;
    logic                 i_txActive;
    logic                 i_txDoneStrobe;
    logic                 o_busy;
    logic [ID_W-1:0]      o_grantId;
    logic                 o_timeoutStrobe;

    modport master (
        input  i_req, i_reqBytes, i_txActive, i_txDoneStrobe,
        output o_ack, o_txStart, o_txByte, o_busy, o_grantId, o_timeoutStrobe
    );

    modport slave (
        output i_req, i_reqBytes, i_txActive, i_txDoneStrobe,
        input  o_ack, o_txStart, o_txByte, o_busy, o_grantId, o_timeoutStrobe
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART_Tx between byte producers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16,
    parameter int ID_W          = 2
) (
    input  logic                i_clk,
    input  logic                i_resetN,
    uart_tx_arbiter_if.master   bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_ACTIVE = 2'd1,
        ST_WAIT_DONE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic [7:0]         w_bytes [NUM_REQ];
    logic               w_sel_valid;
    logic [IDX_W-1:0]   w_sel_idx;
    int                 w_scan;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_bytes[g] = bus.i_reqBytes[8*g +: 8];
    end

    // Scan downward in offset so the lowest offset from the pointer wins.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        w_scan      = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_scan = int'(ptr_q) + i;
            if (w_scan >= NUM_REQ) w_scan = w_scan - NUM_REQ;
            if (bus.i_req[IDX_W'(w_scan)]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = IDX_W'(w_scan);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        cnt_d      = cnt_q;
        tx_byte_d  = tx_byte_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    tx_byte_d           = w_bytes[w_sel_idx];
                    ack_d[w_sel_idx]    = 1'b1;
                    tx_start_d          = 1'b1;
                    grant_id_d          = ID_W'(w_sel_idx);
                    ptr_d               = (int'(w_sel_idx) == NUM_REQ - 1) ? '0
                                          : ID_W'(int'(w_sel_idx) + 1);
                    cnt_d               = '0;
                    state_d             = ST_WAIT_ACTIVE;
                end
            end
            ST_WAIT_ACTIVE: begin
                // Done outranks active: a zero-length transfer returns straight to IDLE.
                if (bus.i_txDoneStrobe) begin
                    state_d = ST_IDLE;
                end else if (bus.i_txActive) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.i_txDoneStrobe || !bus.i_txActive) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            cnt_q      <= '0;
            tx_byte_q  <= 8'h00;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            cnt_q      <= cnt_d;
            tx_byte_q  <= tx_byte_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.o_ack           = ack_q;
    assign bus.o_txStart       = tx_start_q;
    assign bus.o_txByte        = tx_byte_q;
    assign bus.o_busy          = busy_q;
    assign bus.o_grantId       = grant_id_q;
    assign bus.o_timeoutStrobe = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter with a round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TO  = 16;
    localparam int IDW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   rr          = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TO), .ID_W(IDW)) dut (
        .i_clk    (clk),
        .i_resetN (rst_n),
        .bus      (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.i_req = '0; bus.i_reqBytes = '0;
        bus.i_txActive = 1'b0; bus.i_txDoneStrobe = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        rr = 0;
    endtask

    // Transmitter model: active for a while, then done strobe; leaves arbiter in IDLE.
    task automatic finish_tx(input int active_cycles);
        bus.i_txActive = 1'b1;
        repeat (active_cycles) step();
        bus.i_txDoneStrobe = 1'b1; bus.i_txActive = 1'b0;
        step();
        bus.i_txDoneStrobe = 1'b0;
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r = req >> ((ptr + i) % N);
            if (r[0]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        bus.i_req = '0; bus.i_reqBytes = '0;
        bus.i_txActive = 1'b0; bus.i_txDoneStrobe = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        vectors++; if (bus.o_ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack got=%b exp=0000", bus.o_ack); end
        vectors++; if (bus.o_txStart !== 1'b0) begin miscompares++; $display("FAIL reset_txStart got=%b exp=0", bus.o_txStart); end
        vectors++; if (bus.o_txByte !== 8'h00) begin miscompares++; $display("FAIL reset_txByte got=%h exp=00", bus.o_txByte); end
        vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
        vectors++; if (bus.o_grantId !== 2'd0) begin miscompares++; $display("FAIL reset_grantId got=%0d exp=0", bus.o_grantId); end
        vectors++; if (bus.o_timeoutStrobe !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got=%b exp=0", bus.o_timeoutStrobe); end
        step(); rst_n = 1'b1; step(); step();
        vectors++; if (bus.o_busy !== 1'b0 || bus.o_txStart !== 1'b0) begin miscompares++; $display("FAIL idle_no_req busy=%b txStart=%b exp 0/0", bus.o_busy, bus.o_txStart); end
        rr = 0;
    endtask

    task automatic test_single();
        apply_reset();
        bus.i_reqBytes = 32'h33_44_A5_11;
        bus.i_req = 4'b0010;
        step();
        vectors++; if (bus.o_ack !== 4'b0010) begin miscompares++; $display("FAIL single_ack got=%b exp=0010", bus.o_ack); end
        vectors++; if (bus.o_txStart !== 1'b1) begin miscompares++; $display("FAIL single_txStart got=%b exp=1", bus.o_txStart); end
        vectors++; if (bus.o_txByte !== 8'hA5) begin miscompares++; $display("FAIL single_txByte got=%h exp=a5", bus.o_txByte); end
        vectors++; if (bus.o_grantId !== 2'd1) begin miscompares++; $display("FAIL single_grantId got=%0d exp=1", bus.o_grantId); end
        vectors++; if (bus.o_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b exp=1", bus.o_busy); end
        bus.i_req = 4'b0000; bus.i_txActive = 1'b1;
        step();
        vectors++; if (bus.o_txStart !== 1'b0 || bus.o_ack !== 4'b0000) begin miscompares++; $display("FAIL single_pulse_width txStart=%b ack=%b exp 0/0000", bus.o_txStart, bus.o_ack); end
        repeat (3) step();
        bus.i_txDoneStrobe = 1'b1; bus.i_txActive = 1'b0;
        vectors++; if (bus.o_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_held got=%b exp=1", bus.o_busy); end
        step();
        bus.i_txDoneStrobe = 1'b0;
        vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_after_done got=%b exp=0", bus.o_busy); end
        vectors++; if (bus.o_txByte !== 8'hA5) begin miscompares++; $display("FAIL single_byte_hold got=%h exp=a5", bus.o_txByte); end
    endtask

    task automatic test_fairness();
        int k;
        apply_reset();
        bus.i_reqBytes = 32'h13_12_11_10;
        bus.i_req = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            k = n % N;
            step();
            vectors++; if (bus.o_txStart !== 1'b1 || bus.o_grantId !== 2'(k) || bus.o_ack !== 4'(1 << k)) begin
                miscompares++; $display("FAIL fair_grant n=%0d txStart=%b id=%0d ack=%b exp 1/%0d/%b", n, bus.o_txStart, bus.o_grantId, bus.o_ack, k, 4'(1 << k)); end
            vectors++; if (bus.o_txByte !== 8'(8'h10 + k)) begin miscompares++; $display("FAIL fair_byte n=%0d got=%h exp=%h", n, bus.o_txByte, 8'(8'h10 + k)); end
            bus.i_txActive = 1'b1;
            step();
            vectors++; if (bus.o_txStart !== 1'b0 || bus.o_ack !== 4'b0000) begin miscompares++; $display("FAIL fair_single_start n=%0d txStart=%b ack=%b exp 0/0000", n, bus.o_txStart, bus.o_ack); end
            step();
            bus.i_txDoneStrobe = 1'b1; bus.i_txActive = 1'b0;
            step();
            bus.i_txDoneStrobe = 1'b0;
            vectors++; if (bus.o_txStart !== 1'b0) begin miscompares++; $display("FAIL fair_gap n=%0d txStart=%b exp=0", n, bus.o_txStart); end
        end
        bus.i_req = 4'b0000;
        step();
    endtask

    task automatic test_wrap_skip();
        apply_reset();
        bus.i_reqBytes = 32'hD3_C2_B1_A0;
        bus.i_req = 4'b0100;
        step();
        vectors++; if (bus.o_grantId !== 2'd2) begin miscompares++; $display("FAIL wrap_first got=%0d exp=2", bus.o_grantId); end
        bus.i_req = 4'b0000;
        finish_tx(2);
        bus.i_req = 4'b0101;
        step();
        vectors++; if (bus.o_grantId !== 2'd0 || bus.o_txByte !== 8'hA0) begin miscompares++; $display("FAIL wrap_to_zero id=%0d byte=%h exp 0/a0", bus.o_grantId, bus.o_txByte); end
        bus.i_req = 4'b0100;
        finish_tx(1);
        step();
        vectors++; if (bus.o_grantId !== 2'd2 || bus.o_txByte !== 8'hC2) begin miscompares++; $display("FAIL skip_to_two id=%0d byte=%h exp 2/c2", bus.o_grantId, bus.o_txByte); end
        bus.i_req = 4'b0000;
        finish_tx(1);
    endtask

    task automatic test_timeout();
        int seen;
        apply_reset();
        bus.i_reqBytes = 32'h04_03_02_01;
        bus.i_req = 4'b0001;
        step();
        bus.i_req = 4'b0010;
        seen = -1;
        for (int i = 1; i <= TO + 4; i++) begin
            step();
            if (bus.o_timeoutStrobe === 1'b1) begin seen = i; break; end
        end
        vectors++; if (seen != TO) begin miscompares++; $display("FAIL timeout_latency got=%0d exp=%0d", seen, TO); end
        vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL timeout_idle busy=%b exp=0", bus.o_busy); end
        step();
        vectors++; if (bus.o_txStart !== 1'b1 || bus.o_grantId !== 2'd1 || bus.o_timeoutStrobe !== 1'b0) begin
            miscompares++; $display("FAIL timeout_next_grant txStart=%b id=%0d to=%b exp 1/1/0", bus.o_txStart, bus.o_grantId, bus.o_timeoutStrobe); end
        bus.i_req = 4'b0000;
        finish_tx(1);
    endtask

    task automatic test_coincidence();
        apply_reset();
        bus.i_reqBytes = 32'h00_00_00_5C;
        bus.i_req = 4'b0001;
        step();
        bus.i_req = 4'b0000; bus.i_txActive = 1'b1;
        step(); step();
        bus.i_txDoneStrobe = 1'b1; bus.i_txActive = 1'b0; bus.i_req = 4'b0001;
        step();
        bus.i_txDoneStrobe = 1'b0;
        vectors++; if (bus.o_txStart !== 1'b0 || bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL coinc_no_early_start txStart=%b busy=%b exp 0/0", bus.o_txStart, bus.o_busy); end
        step();
        vectors++; if (bus.o_txStart !== 1'b1 || bus.o_ack !== 4'b0001) begin miscompares++; $display("FAIL coinc_start txStart=%b ack=%b exp 1/0001", bus.o_txStart, bus.o_ack); end
        bus.i_req = 4'b0000;
        finish_tx(1);
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.i_reqBytes = 32'h77_00_5A_00;
        bus.i_req = 4'b0010;
        step();
        bus.i_req = 4'b0000; bus.i_txActive = 1'b1;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus.o_busy !== 1'b0 || bus.o_txByte !== 8'h00 || bus.o_grantId !== 2'd0) begin
            miscompares++; $display("FAIL async_reset busy=%b byte=%h id=%0d exp 0/00/0", bus.o_busy, bus.o_txByte, bus.o_grantId); end
        #2 rst_n = 1'b1;
        step();
        vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL async_reset_idle busy=%b exp=0", bus.o_busy); end
        bus.i_req = 4'b1000;
        step();
        vectors++; if (bus.o_grantId !== 2'd3 || bus.o_ack !== 4'b1000 || bus.o_txByte !== 8'h77) begin
            miscompares++; $display("FAIL async_first_grant id=%0d ack=%b byte=%h exp 3/1000/77", bus.o_grantId, bus.o_ack, bus.o_txByte); end
        bus.i_req = 4'b0000;
        finish_tx(1);
    endtask

    task automatic test_random();
        logic [N-1:0] pending;
        logic [7:0]   bytes [N];
        logic [1:0]   prev_cur;
        int exp_k, mode;
        apply_reset();
        pending = '0;
        for (int k = 0; k < N; k++) bytes[k] = 8'h00;
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < N; k++)
                if (!pending[k] && $urandom_range(0, 1) == 1) begin pending[k] = 1'b1; bytes[k] = 8'($urandom); end
            if (pending == '0) begin
                exp_k = $urandom_range(0, N - 1);
                pending[exp_k] = 1'b1; bytes[exp_k] = 8'($urandom);
            end
            for (int k = 0; k < N; k++) bus.i_reqBytes[8*k +: 8] = bytes[k];
            bus.i_req = pending;
            exp_k = rr_pick(pending, rr);
            step();
            vectors++; if ({bus.o_txStart, bus.o_ack, bus.o_grantId} !== {1'b1, 4'(1 << exp_k), 2'(exp_k)}) begin
                miscompares++; $display("FAIL rand_grant r=%0d txStart=%b ack=%b id=%0d exp 1/%b/%0d", r, bus.o_txStart, bus.o_ack, bus.o_grantId, 4'(1 << exp_k), exp_k); end
            vectors++; if (bus.o_txByte !== bytes[exp_k]) begin miscompares++; $display("FAIL rand_byte r=%0d got=%h exp=%h", r, bus.o_txByte, bytes[exp_k]); end
            rr = (exp_k + 1) % N;
            pending[exp_k] = 1'b0;
            bus.i_req = pending;
            mode = $urandom_range(0, 3);
            case (mode)
                0: finish_tx($urandom_range(1, 6));
                1: begin
                    bus.i_txDoneStrobe = 1'b1;
                    step();
                    bus.i_txDoneStrobe = 1'b0;
                end
                2: begin
                    repeat (TO - 1) step();
                    prev_cur[1] = bus.o_timeoutStrobe;
                    step();
                    prev_cur[0] = bus.o_timeoutStrobe;
                    vectors++; if (prev_cur !== 2'b01) begin miscompares++; $display("FAIL rand_timeout r=%0d got=%b exp=01", r, prev_cur); end
                end
                default: begin
                    bus.i_txActive = 1'b1;
                    step();
                    bus.i_txActive = 1'b0;
                    step();
                end
            endcase
            vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL rand_return_idle r=%0d mode=%0d busy=%b exp=0", r, mode, bus.o_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap_skip();
        test_timeout();
        test_coincidence();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART_Tx instance (CLKS_PER_BIT 217, 8 data bits) between NUM_REQ byte producers, e.g. the RX echo path, a status reporter and a debug dump. It captures one byte from the winning requester and issues a single-cycle start pulse to UART_Tx. It then tracks the transmitter through completion before granting again. It sits between the requesters and UART_Tx in the top level and fully owns UART_Tx's i_txStart and i_txByte.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
START_TIMEOUT, 16, max cycles to wait for i_txActive after a start pulse
ID_W, 2, width of the grant-id output; must satisfy 2^ID_W >= NUM_REQ

Ports:
i_clk  in  1  system clock
i_resetN  in  1  asynchronous active-low reset
i_req  in  NUM_REQ  per-requester level request; byte must be held stable while high
i_reqBytes  in  8*NUM_REQ  packed bytes; requester k occupies bits [8k+7:8k]
o_ack  out  NUM_REQ  one-hot, 1-cycle pulse: byte of requester k captured
o_txStart  out  1  1-cycle start pulse to UART_Tx i_txStart
o_txByte  out  8  byte to UART_Tx i_txByte; held constant from capture until next capture
i_txActive  in  1  from UART_Tx o_txActive
i_txDoneStrobe  in  1  from UART_Tx o_txDoneStrobe
o_busy  out  1  high in every state except IDLE
o_grantId  out  ID_W  index of the last granted requester
o_timeoutStrobe  out  1  1-cycle pulse when a start is not acknowledged by i_txActive

Behaviour:
- Reset (asynchronous, i_resetN=0): state=IDLE; o_ack=0, o_txStart=0, o_txByte=8'h00, o_busy=0, o_grantId=0, o_timeoutStrobe=0; round-robin pointer=0; timeout counter=0.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, WAIT_ACTIVE, WAIT_DONE.
- IDLE:
  - If any i_req bit is high, select the first set bit scanning from the pointer upward with wrap-around.
  - At the next edge: o_txByte<=selected byte; o_ack[k]<=1; o_txStart<=1; o_grantId<=k; pointer<=(k+1) mod NUM_REQ; counter<=0; state<=WAIT_ACTIVE.
  - Latency from i_req rising to o_ack/o_txStart high is 1 cycle.
- o_ack and o_txStart are high for exactly one cycle.
- Requester k must drop or refresh i_req in the cycle after its o_ack. A req still high then is treated as a new request.
- WAIT_ACTIVE:
  - Counter increments every cycle.
  - i_txActive=1 -> WAIT_DONE.
  - i_txDoneStrobe=1 without i_txActive seen (zero-length transfer) -> IDLE.
  - Counter reaches START_TIMEOUT-1 with neither -> o_timeoutStrobe 1-cycle pulse, state<=IDLE. The byte is dropped and not retried.
  - i_txActive and i_txDoneStrobe high in the same cycle -> done takes priority -> IDLE.
- WAIT_DONE: i_txDoneStrobe=1 -> IDLE. i_txActive falling without the strobe also -> IDLE (defensive).
- Requests arriving in any non-IDLE state are ignored until IDLE. Arbitration happens in IDLE, so there is a minimum 1-cycle gap between the done strobe and the next o_txStart.
- Done strobe coincident with new requests: state goes IDLE at that edge; arbitration occurs the following edge.
- Requests raised and dropped while busy are lost. The requester must hold i_req until acked.
- Reset mid-transfer: all state clears immediately. UART_Tx may still complete its frame and emit a late done strobe. In IDLE the strobe and i_txActive are ignored, but a new o_txStart may issue while UART_Tx is still active. The top level must reset both blocks together.
- Bits of i_req at index >= NUM_REQ do not exist. The pointer never exceeds NUM_REQ-1.

Test Plan:
- Single request: i_req=4'b0010, byte1=8'hA5 -> next cycle o_ack=4'b0010, o_txStart=1, o_txByte=8'hA5, o_grantId=1. o_busy stays high until 1 cycle after i_txDoneStrobe. UART line carries 0xA5 at 217 clocks/bit.
- Fairness: i_req=4'b1111 held permanently, bytes 8'h10/8'h11/8'h12/8'h13 -> grant order 0,1,2,3,0,... Exactly one o_ack per transfer. Never two o_txStart pulses without a done strobe between them.
- Wrap and skip: pointer=3, i_req=4'b0101 -> grant 0, then grant 2.
- Timeout: model holds i_txActive=0 after start -> o_timeoutStrobe pulses exactly START_TIMEOUT cycles after o_txStart. State returns to IDLE, and a pending request is granted on the next cycle.
- Coincidence: i_txDoneStrobe and a new i_req=4'b0001 in the same cycle -> o_txStart two cycles later, not one.
- Async reset: assert i_resetN=0 mid-byte with no clock edge -> o_busy=0, o_txByte=8'h00, o_grantId=0 immediately. After release, i_req=4'b1000 is granted first, with id 3.
